// File: rtl/alien_sprite_pipeline.sv
`default_nettype none
// ============================================================================
//  Module   : alien_sprite_pipeline
//  Purpose  : Per-pixel alien sprite hit test over N_ALIENS shadowed objects,
//             with a 3-stage pipeline that produces the winning (nearest)
//             sprite's ROM address and frame select.
//  Revision : 1.0 - initial release
// ============================================================================
module alien_sprite_pipeline #(
    parameter int N_ALIENS   = 4,
    parameter int SPRITE_DIM = 32,
    parameter int ADDR_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start_i,
    input  logic                    pix_valid_i,
    input  logic [9:0]              h_cnt_i,
    input  logic [9:0]              v_cnt_i,
    input  logic [N_ALIENS-1:0]     obj_en_i,
    input  logic [N_ALIENS*10-1:0]  obj_x_i,
    input  logic [N_ALIENS*10-1:0]  obj_y_i,
    input  logic [N_ALIENS*10-1:0]  obj_r_i,
    input  logic [N_ALIENS*2-1:0]   obj_deriv_left_i,
    input  logic [N_ALIENS*2-1:0]   obj_deriv_right_i,
    output logic                    out_strobe_o,
    output logic                    valid_o,
    output logic [2:0]              alien_idx_o,
    output logic [1:0]              deriv_select_o,
    output logic [ADDR_W-1:0]       pixel_addr_o
);

    localparam logic [9:0] SPRITE_DIM10 = 10'(SPRITE_DIM);

    // Shadow object table, only ever written on frame_start
    logic [N_ALIENS-1:0]    en_q;
    logic [N_ALIENS*10-1:0] x_q, y_q, r_q;
    logic [N_ALIENS*2-1:0]  dl_q, dr_q;

    // Stage 1: per-channel hit and sprite coordinates
    logic [N_ALIENS-1:0]       s1_hit_d, s1_hit_q;
    logic [N_ALIENS-1:0][9:0]  s1_row_d, s1_row_q;
    logic [N_ALIENS-1:0][9:0]  s1_col_d, s1_col_q;
    logic [N_ALIENS-1:0][9:0]  s1_hw_d,  s1_hw_q;
    logic [N_ALIENS-1:0][9:0]  s1_r_q;
    logic [N_ALIENS-1:0][1:0]  s1_der_d, s1_der_q;

    // Stage 2: per-channel ROM address
    logic [N_ALIENS-1:0]             s2_hit_q;
    logic [N_ALIENS-1:0][ADDR_W-1:0] s2_addr_d, s2_addr_q;
    logic [N_ALIENS-1:0][9:0]        s2_r_q;
    logic [N_ALIENS-1:0][1:0]        s2_der_q;

    // Stage 3: arbitrated result
    logic [2:0]        stb_q;
    logic              valid_d;
    logic [2:0]        idx_d;
    logic [1:0]        der_d;
    logic [ADDR_W-1:0] addr_d;

    // Capture the object table at the start of each frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= '0;
            x_q  <= '0;
            y_q  <= '0;
            r_q  <= '0;
            dl_q <= '0;
            dr_q <= '0;
        end else if (frame_start_i) begin
            en_q <= obj_en_i;
            x_q  <= obj_x_i;
            y_q  <= obj_y_i;
            r_q  <= obj_r_i;
            dl_q <= obj_deriv_left_i;
            dr_q <= obj_deriv_right_i;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_ALIENS; gi++) begin : g_ch
            logic [9:0]        w_x, w_y, w_r, w_hw, w_dcol;
            logic              w_live, w_vhit, w_right;
            // 12-bit signed keeps y-hw negative and y+hw un-wrapped
            logic signed [11:0] w_v, w_ys, w_hws, w_top, w_bot, w_row;

            assign w_x    = x_q[gi*10 +: 10];
            assign w_y    = y_q[gi*10 +: 10];
            assign w_r    = r_q[gi*10 +: 10];
            assign w_hw   = SPRITE_DIM10 - w_r;
            assign w_live = en_q[gi] && (w_r < SPRITE_DIM10);

            assign w_v    = {2'b00, v_cnt_i};
            assign w_ys   = {2'b00, w_y};
            assign w_hws  = {2'b00, w_hw};
            assign w_top  = w_ys - w_hws;
            assign w_bot  = w_ys + w_hws;
            assign w_vhit = (w_v >= w_top) && (w_v < w_bot);
            assign w_row  = w_v - w_top;

            // Left half is mirrored about the centre column
            assign w_right = (h_cnt_i >= w_x);
            assign w_dcol  = w_right ? (h_cnt_i - w_x) : (w_x - 10'd1 - h_cnt_i);

            assign s1_hit_d[gi] = w_live && w_vhit && (w_dcol < w_hw);
            assign s1_row_d[gi] = w_row[9:0];
            assign s1_col_d[gi] = w_dcol;
            assign s1_hw_d[gi]  = w_hw;
            assign s1_der_d[gi] = w_right ? dr_q[gi*2 +: 2] : dl_q[gi*2 +: 2];

            assign s2_addr_d[gi] = ADDR_W'(({10'd0, s1_row_q[gi]} * {10'd0, s1_hw_q[gi]})
                                           + {10'd0, s1_col_q[gi]});
        end
    endgenerate

    // Stage 1 and stage 2 registers; r travels with the pixel for arbitration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hit_q  <= '0;
            s1_row_q  <= '0;
            s1_col_q  <= '0;
            s1_hw_q   <= '0;
            s1_r_q    <= '0;
            s1_der_q  <= '0;
            s2_hit_q  <= '0;
            s2_addr_q <= '0;
            s2_r_q    <= '0;
            s2_der_q  <= '0;
        end else begin
            s1_hit_q  <= s1_hit_d;
            s1_row_q  <= s1_row_d;
            s1_col_q  <= s1_col_d;
            s1_hw_q   <= s1_hw_d;
            s1_r_q    <= r_q;
            s1_der_q  <= s1_der_d;
            s2_hit_q  <= s1_hit_q;
            s2_addr_q <= s2_addr_d;
            s2_r_q    <= s1_r_q;
            s2_der_q  <= s1_der_q;
        end
    end

    // Nearest (smallest r) hitting channel wins; ascending scan keeps lowest index on ties
    always_comb begin
        logic       found;
        logic [9:0] best_r;
        found   = 1'b0;
        best_r  = '0;
        valid_d = 1'b0;
        idx_d   = '0;
        der_d   = '0;
        addr_d  = '0;
        for (int i = 0; i < N_ALIENS; i++) begin
            if (s2_hit_q[i] && (!found || (s2_r_q[i] < best_r))) begin
                found  = 1'b1;
                best_r = s2_r_q[i];
                idx_d  = 3'(i);
                der_d  = s2_der_q[i];
                addr_d = s2_addr_q[i];
            end
        end
        if (!(found && stb_q[1])) begin
            idx_d  = '0;
            der_d  = '0;
            addr_d = '0;
        end else begin
            valid_d = 1'b1;
        end
    end

    // Strobe delay line and stage 3 output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_q          <= '0;
            valid_o        <= 1'b0;
            alien_idx_o    <= '0;
            deriv_select_o <= '0;
            pixel_addr_o   <= '0;
        end else begin
            stb_q          <= {stb_q[1:0], pix_valid_i};
            valid_o        <= valid_d;
            alien_idx_o    <= idx_d;
            deriv_select_o <= der_d;
            pixel_addr_o   <= addr_d;
        end
    end

    assign out_strobe_o = stb_q[2];

endmodule
`default_nettype wire
